imsic_msi_sched: RTL and testbench

//  Round-robin arbiter and pulse sequencer for MSI delivery into the IMSIC CSR gate.

---
 rtl/imsic_msi_sched_if.sv | 16 +
 rtl/imsic_msi_sched.sv | 166 ++++++++++++++++
 tb/tb_imsic_msi_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imsic_msi_sched_if.sv
// Requester-side MSI bus for imsic_msi_sched.
//   req_vld   per-requester MSI valid
//   req_info  requester i info word at [i*MSI_INFO_WIDTH +: MSI_INFO_WIDTH]
//   req_rdy   one-hot grant; a word is accepted when req_vld[i] & req_rdy[i]
// master: the requesters; slave: the scheduler.
interface imsic_msi_sched_if #(
   parameter int NR_REQ         = 2,
   parameter int MSI_INFO_WIDTH = 17
);
   logic [NR_REQ-1:0]                req_vld;
   logic [NR_REQ*MSI_INFO_WIDTH-1:0] req_info;
   logic [NR_REQ-1:0]                req_rdy;

   modport master (output req_vld, output req_info, input req_rdy);
   modport slave  (input req_vld, input req_info, output req_rdy);
endinterface

// File: rtl/imsic_msi_sched.sv
// Round-robin arbiter and pulse sequencer delivering MSI info words into the
// IMSIC CSR gate. Words from NR_REQ requesters are buffered in a shared FIFO
// and presented one at a time as o_msi_info with a fixed-length high/low pulse
// on o_msi_info_vld; the gate captures info on the falling edge of vld.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   req_bus         requester handshake (imsic_msi_sched_if.slave)
//   o_msi_info      info word to the gate, changes only when a word is popped
//   o_msi_info_vld  registered pulse to the gate
//   fifo_cnt        current FIFO occupancy
//   busy            sequencer active or FIFO non-empty
module imsic_msi_sched #(
   parameter int NR_REQ         = 2,
   parameter int MSI_INFO_WIDTH = 17,
   parameter int FIFO_DEPTH     = 4,
   parameter int VLD_HIGH_CYC   = 4,
   parameter int VLD_LOW_CYC    = 4
) (
   input  logic                              clk,
   input  logic                              rstn,
   imsic_msi_sched_if.slave                  req_bus,
   output logic [MSI_INFO_WIDTH-1:0]         o_msi_info,
   output logic                              o_msi_info_vld,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt,
   output logic                              busy
);

   localparam int          CW     = $clog2(FIFO_DEPTH + 1);
   localparam int          AW     = $clog2(FIFO_DEPTH);
   localparam int          PW     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
   localparam int          PH_MAX = (VLD_HIGH_CYC > VLD_LOW_CYC) ? VLD_HIGH_CYC : VLD_LOW_CYC;
   localparam int          TW     = $clog2(PH_MAX + 1);
   localparam int unsigned NR_U   = NR_REQ;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_HIGH  = 2'd2;
   localparam logic [1:0] S_LOW   = 2'd3;

   logic [MSI_INFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [PW-1:0]             ptr_q, ptr_d;
   logic [1:0]                state_q, state_d;
   logic [TW-1:0]             tmr_q, tmr_d;
   logic                      vld_q, vld_d;
   logic [MSI_INFO_WIDTH-1:0] info_q, info_d;

   logic [NR_REQ-1:0]         gnt;
   logic [PW-1:0]             gnt_idx;
   logic                      found;
   int unsigned               arb_idx;
   logic                      full, accept, pop;

   assign full   = (cnt_q == CW'(FIFO_DEPTH));
   assign pop    = (state_q == S_IDLE) && (cnt_q != '0);
   assign accept = |gnt;

   // Search upward from the last granted index; at most one grant per cycle.
   always_comb begin
      gnt     = '0;
      gnt_idx = ptr_q;
      found   = 1'b0;
      arb_idx = 0;
      if (!full) begin
         for (int unsigned off = 1; off <= NR_U; off++) begin
            arb_idx = (32'(ptr_q) + off) % NR_U;
            if (!found && req_bus.req_vld[PW'(arb_idx)]) begin
               found              = 1'b1;
               gnt[PW'(arb_idx)]  = 1'b1;
               gnt_idx            = PW'(arb_idx);
            end
         end
      end
   end

   assign req_bus.req_rdy = gnt;
   assign ptr_d           = accept ? gnt_idx : ptr_q;

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage is not reset; emptiness is tracked by cnt_q/pointers alone.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= req_bus.req_info[32'(gnt_idx)*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ptr_q    <= PW'(NR_REQ - 1);
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
         ptr_q <= ptr_d;
      end
   end

   // vld is registered: it is set on the SETUP->HIGH edge and cleared on HIGH->LOW.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      vld_d   = vld_q;
      info_d  = info_q;
      case (state_q)
         S_IDLE: begin
            vld_d = 1'b0;
            if (cnt_q != '0) begin
               info_d  = mem_q[rd_ptr_q];
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            tmr_d   = TW'(VLD_HIGH_CYC - 1);
            vld_d   = 1'b1;
            state_d = S_HIGH;
         end
         S_HIGH: begin
            if (tmr_q == '0) begin
               tmr_d   = TW'(VLD_LOW_CYC - 1);
               vld_d   = 1'b0;
               state_d = S_LOW;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_LOW: begin
            if (tmr_q == '0) state_d = S_IDLE;
            else             tmr_d   = tmr_q - 1'b1;
         end
         default: begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         vld_q   <= 1'b0;
         info_q  <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         vld_q   <= vld_d;
         info_q  <= info_d;
      end
   end

   assign o_msi_info     = info_q;
   assign o_msi_info_vld = vld_q;
   assign fifo_cnt       = cnt_q;
   assign busy           = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_imsic_msi_sched.sv
// Self-checking bench for imsic_msi_sched: random requester traffic against a
// queue-based reference model of arbitration, buffering and pulse timing, plus
// a CSR-gate model that captures o_msi_info on each falling edge of vld.
module tb_imsic_msi_sched;
   localparam int NR = 2;
   localparam int W  = 17;
   localparam int D  = 4;
   localparam int H  = 4;
   localparam int L  = 4;
   localparam int CW = $clog2(D + 1);

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   imsic_msi_sched_if #(.NR_REQ(NR), .MSI_INFO_WIDTH(W)) bus ();

   logic [W-1:0]  o_msi_info;
   logic          o_msi_info_vld;
   logic [CW-1:0] fifo_cnt;
   logic          busy;

   imsic_msi_sched #(
      .NR_REQ(NR), .MSI_INFO_WIDTH(W), .FIFO_DEPTH(D),
      .VLD_HIGH_CYC(H), .VLD_LOW_CYC(L)
   ) dut (
      .clk(clk), .rstn(rstn), .req_bus(bus),
      .o_msi_info(o_msi_info), .o_msi_info_vld(o_msi_info_vld),
      .fifo_cnt(fifo_cnt), .busy(busy)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Reference model state
   logic [W-1:0] mq[$];          // buffered words
   int           mptr;           // last granted requester
   bit           mactive;        // a word is being delivered
   int           mk;             // edges since the word was popped
   logic [W-1:0] mout;           // word presented to the gate
   logic [W-1:0] src[NR][$];     // words each requester still has to send
   bit           present[NR];    // requester currently offering src[i][0]
   logic [W-1:0] exp_deliv[$];   // words the gate should capture, in order
   int           glog[$];        // grant order
   bit           prev_vld;
   int           rate = 100;
   int           vld_hi_cnt;
   int           max_cnt;

   function automatic int model_grant();
      if (mq.size() >= D) return -1;
      for (int off = 1; off <= NR; off++) begin
         int idx;
         idx = (mptr + off) % NR;
         if (bus.req_vld[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic bit all_idle();
      for (int i = 0; i < NR; i++)
         if (src[i].size() != 0 || present[i]) return 1'b0;
      return (mq.size() == 0) && !mactive;
   endfunction

   task automatic model_reset();
      mq.delete();
      mptr    = NR - 1;
      mactive = 1'b0;
      mk      = 0;
      mout    = '0;
      for (int i = 0; i < NR; i++) begin
         src[i].delete();
         present[i] = 1'b0;
      end
      exp_deliv.delete();
      prev_vld = 1'b0;
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (!present[i] && src[i].size() != 0 && $urandom_range(0, 99) < rate)
            present[i] = 1'b1;
         bus.req_vld[i] = present[i];
         bus.req_info[i*W +: W] = present[i] ? src[i][0] : W'($urandom);
      end
   endtask

   task automatic check_outputs();
      logic          e_vld;
      logic [NR-1:0] e_rdy;
      int            g;
      e_vld = mactive && mk >= 1 && mk <= H;
      e_rdy = '0;
      g = model_grant();
      if (g >= 0) e_rdy[g] = 1'b1;
      checks++;
      if (o_msi_info_vld !== e_vld) begin
         errors++;
         $display("FAIL vld t=%0t got=%b exp=%b", $time, o_msi_info_vld, e_vld);
      end
      checks++;
      if (o_msi_info !== mout) begin
         errors++;
         $display("FAIL info t=%0t got=%h exp=%h", $time, o_msi_info, mout);
      end
      checks++;
      if (fifo_cnt !== CW'(mq.size())) begin
         errors++;
         $display("FAIL fifo_cnt t=%0t got=%0d exp=%0d", $time, fifo_cnt, mq.size());
      end
      checks++;
      if (busy !== (mactive || mq.size() != 0)) begin
         errors++;
         $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, (mactive || mq.size() != 0));
      end
      checks++;
      if (bus.req_rdy !== e_rdy) begin
         errors++;
         $display("FAIL req_rdy t=%0t got=%b exp=%b", $time, bus.req_rdy, e_rdy);
      end
      // Gate model: capture on the falling edge of vld
      if (prev_vld && !o_msi_info_vld) begin
         checks++;
         if (exp_deliv.size() == 0) begin
            errors++;
            $display("FAIL gate_capture t=%0t got=%h exp=none", $time, o_msi_info);
         end else begin
            logic [W-1:0] e;
            e = exp_deliv.pop_front();
            if (o_msi_info !== e) begin
               errors++;
               $display("FAIL gate_capture t=%0t got=%h exp=%h", $time, o_msi_info, e);
            end
         end
      end
      prev_vld = o_msi_info_vld;
      if (o_msi_info_vld === 1'b1) vld_hi_cnt++;
      if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
   endtask

   task automatic step();
      int g;
      int pre;
      @(posedge clk);
      g   = model_grant();
      pre = mq.size();
      if (!mactive && pre > 0) begin
         mout    = mq.pop_front();
         mactive = 1'b1;
         mk      = 0;
      end else if (mactive) begin
         mk++;
         if (mk == 1 + H + L) mactive = 1'b0;
      end
      if (g >= 0) begin
         mq.push_back(bus.req_info[g*W +: W]);
         exp_deliv.push_back(bus.req_info[g*W +: W]);
         glog.push_back(g);
         mptr = g;
         void'(src[g].pop_front());
         present[g] = 1'b0;
      end
   endtask

   task automatic cycle();
      step();
      #1;
      drive();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run_drain(input int budget, input string tag);
      for (int n = 0; n < budget; n++) begin
         if (all_idle()) break;
         cycle();
      end
      repeat (2) cycle();
      checks++;
      if (!all_idle()) begin
         errors++;
         $display("FAIL drain_timeout_%s got=busy exp=idle", tag);
      end
      checks++;
      if (exp_deliv.size() != 0) begin
         errors++;
         $display("FAIL undelivered_%s got=%0d exp=0", tag, exp_deliv.size());
      end
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      bus.req_vld  = '0;
      bus.req_info = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      drive();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.req_vld  = '0;
      bus.req_info = '0;
      model_reset();
      #12;
      checks++;
      if (o_msi_info_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", o_msi_info_vld); end
      checks++;
      if (o_msi_info !== '0) begin errors++; $display("FAIL reset_info got=%h exp=0", o_msi_info); end
      checks++;
      if (fifo_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (bus.req_rdy !== '0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", bus.req_rdy); end
      @(negedge clk);
      rstn = 1'b1;
      drive();
   endtask

   task automatic test_single();
      apply_reset();
      rate = 100;
      vld_hi_cnt = 0;
      src[0].push_back(17'h1_0005);
      drive();
      run_drain(100, "single");
      checks++;
      if (vld_hi_cnt != H) begin
         errors++;
         $display("FAIL single_vld_width got=%0d exp=%0d", vld_hi_cnt, H);
      end
   endtask

   task automatic test_alternate();
      apply_reset();
      rate = 100;
      glog.delete();
      for (int k = 0; k < 4; k++) begin
         src[0].push_back(W'($urandom));
         src[1].push_back(W'($urandom));
      end
      drive();
      run_drain(400, "alternate");
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (k >= glog.size() || glog[k] != k % 2) begin
            errors++;
            $display("FAIL alt_grant_%0d got=%0d exp=%0d", k, (k < glog.size()) ? glog[k] : -1, k % 2);
         end
      end
   endtask

   task automatic test_stream_full();
      apply_reset();
      rate = 100;
      max_cnt = 0;
      for (int k = 0; k < 6; k++) src[1].push_back(W'($urandom));
      drive();
      run_drain(400, "stream");
      checks++;
      if (max_cnt != D) begin
         errors++;
         $display("FAIL stream_max_cnt got=%0d exp=%0d", max_cnt, D);
      end
   endtask

   task automatic test_random_mix();
      apply_reset();
      for (int r = 0; r < 3; r++) begin
         rate = (r == 0) ? 30 : (r == 1) ? 70 : 100;
         for (int k = 0; k < 12; k++) begin
            src[0].push_back(W'($urandom));
            src[1].push_back(W'($urandom));
         end
         drive();
         run_drain(2000, "random");
      end
   endtask

   task automatic test_reset_mid_high();
      bit hit;
      apply_reset();
      rate = 100;
      hit = 1'b0;
      for (int k = 0; k < 3; k++) src[0].push_back(W'($urandom));
      drive();
      for (int n = 0; n < 100; n++) begin
         cycle();
         if (mactive && mk >= 1 && mk <= H && mq.size() > 0) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL midhigh_reach got=0 exp=1");
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (o_msi_info_vld !== 1'b0) begin errors++; $display("FAIL midhigh_vld got=%b exp=0", o_msi_info_vld); end
      checks++;
      if (fifo_cnt !== '0) begin errors++; $display("FAIL midhigh_cnt got=%0d exp=0", fifo_cnt); end
      checks++;
      if (o_msi_info !== '0) begin errors++; $display("FAIL midhigh_info got=%h exp=0", o_msi_info); end
      bus.req_vld = '0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      glog.delete();
      src[0].push_back(W'($urandom));
      src[1].push_back(W'($urandom));
      drive();
      run_drain(200, "after_reset");
      checks++;
      if (glog.size() == 0 || glog[0] != 0) begin
         errors++;
         $display("FAIL post_reset_priority got=%0d exp=0", (glog.size() != 0) ? glog[0] : -1);
      end
   endtask

   initial begin
      bus.req_vld  = '0;
      bus.req_info = '0;
      test_reset();
      test_single();
      test_alternate();
      test_stream_full();
      test_random_mix();
      test_reset_mid_high();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
